bits_smem_arbiter: RTL and testbench

Owns the single-port stack SRAM shared by bits_core and the bits_regs host debug port.
- Core accesses always win; the host is served only in idle memory cycles.
- A clear sequencer zeroes a programmable number of stack words before a decode run, holding the core off while it sweeps.
- Sits between bits_core's smem_* outputs and the physical stack memory.

---
 rtl/bits_smem_pkg.sv | 20 ++
 rtl/bits_smem_clear_seq.sv | 62 ++++++
 rtl/bits_smem_arbiter.sv | 115 +++++++++++
 tb/tb_bits_smem_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bits_smem_pkg.sv
// Shared types and default widths for the stack SRAM arbiter and its clear sequencer.
package bits_smem_pkg;

  localparam int unsigned AddrWDef = 16;
  localparam int unsigned DataWDef = 64;
  localparam int unsigned ClrWDef  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } clr_state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnCore,
    OwnHost
  } rd_owner_e;

endpackage

// File: rtl/bits_smem_clear_seq.sv
// Clear sweep sequencer: writes zero to words 0..clear_words-1, then pulses done for one cycle.
module bits_smem_clear_seq
  import bits_smem_pkg::*;
#(
  parameter int unsigned CLR_W = ClrWDef
) (
  input  logic             clk,
  input  logic             resetB,
  input  logic             clear_start_i,
  input  logic [CLR_W-1:0] clear_words_i,
  output logic             clear_busy_o,
  output logic             clear_done_o,
  output logic             wr_en_o,
  output logic [CLR_W-1:0] wr_cnt_o
);

  clr_state_e       state_q, state_d;
  logic [CLR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // A zero-length sweep still passes through CLEAR, just without writing.
        if (clear_words_i == '0) begin
          state_d = StDone;
        end else begin
          wr_en_o = 1'b1;
          cnt_d   = cnt_q + CLR_W'(1);
          if (cnt_q == clear_words_i - CLR_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetB) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clear_busy_o = (state_q != StIdle);
  assign clear_done_o = (state_q == StDone);
  assign wr_cnt_o     = cnt_q;

endmodule

// File: rtl/bits_smem_arbiter.sv
// Stack SRAM owner: clear sweep beats core beats host; host reads are returned registered.
module bits_smem_arbiter
  import bits_smem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned CLR_W  = ClrWDef
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              core_ceb,
  input  logic              core_web,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clear_start,
  input  logic [CLR_W-1:0]  clear_words,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              core_hold,
  output logic              err_core_in_clear,
  output logic              smem_ceb,
  output logic              smem_web,
  output logic [ADDR_W-1:0] smem_addr,
  output logic [DATA_W-1:0] smem_wdata,
  input  logic [DATA_W-1:0] smem_rdata
);

  logic             clr_wr;
  logic [CLR_W-1:0] clr_cnt;

  rd_owner_e         rd_owner_q, rd_owner_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              err_q, err_d;

  bits_smem_clear_seq #(
    .CLR_W(CLR_W)
  ) u_clear_seq (
    .clk          (clk),
    .resetB       (resetB),
    .clear_start_i(clear_start),
    .clear_words_i(clear_words),
    .clear_busy_o (clear_busy),
    .clear_done_o (clear_done),
    .wr_en_o      (clr_wr),
    .wr_cnt_o     (clr_cnt)
  );

  always_comb begin
    smem_ceb   = 1'b1;
    smem_web   = 1'b1;
    smem_addr  = '0;
    smem_wdata = '0;
    host_gnt   = 1'b0;
    rd_owner_d = OwnNone;
    // Nothing reaches the SRAM while reset is asserted, whatever the requesters hold.
    if (!resetB) begin
      smem_ceb = 1'b1;
    end else if (clear_busy) begin
      if (clr_wr) begin
        smem_ceb  = 1'b0;
        smem_web  = 1'b0;
        smem_addr = ADDR_W'(clr_cnt);
      end
    end else if (!core_ceb) begin
      smem_ceb   = 1'b0;
      smem_web   = core_web;
      smem_addr  = core_addr;
      smem_wdata = core_wdata;
      if (core_web) rd_owner_d = OwnCore;
    end else if (host_req) begin
      smem_ceb   = 1'b0;
      smem_web   = ~host_we;
      smem_addr  = host_addr;
      smem_wdata = host_wdata;
      host_gnt   = 1'b1;
      if (!host_we) rd_owner_d = OwnHost;
    end
  end

  always_comb begin
    host_rvalid_d = (rd_owner_q == OwnHost);
    host_rdata_d  = host_rvalid_d ? smem_rdata : host_rdata_q;
    err_d         = err_q | (clear_busy & ~core_ceb);
  end

  always_ff @(posedge clk) begin
    if (!resetB) begin
      rd_owner_q    <= OwnNone;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      rd_owner_q    <= rd_owner_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      err_q         <= err_d;
    end
  end

  assign core_rdata        = smem_rdata;
  assign host_rvalid       = host_rvalid_q;
  assign host_rdata        = host_rdata_q;
  assign err_core_in_clear = err_q;
  assign core_hold         = clear_busy;

endmodule

// File: tb/tb_bits_smem_arbiter.sv
// Directed bench for bits_smem_arbiter: mux vector table plus clear/host-read/priority sequences.
module tb_bits_smem_arbiter;

  logic        clk = 1'b0;
  logic        resetB;
  logic        core_ceb, core_web;
  logic [15:0] core_addr;
  logic [63:0] core_wdata, core_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [15:0] host_addr;
  logic [63:0] host_wdata, host_rdata;
  logic        clear_start, clear_busy, clear_done, core_hold, err_core_in_clear;
  logic [15:0] clear_words;
  logic        smem_ceb, smem_web;
  logic [15:0] smem_addr;
  logic [63:0] smem_wdata, smem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mem [256];

  always #5 clk = ~clk;

  bits_smem_arbiter dut (
    .clk              (clk),
    .resetB           (resetB),
    .core_ceb         (core_ceb),
    .core_web         (core_web),
    .core_addr        (core_addr),
    .core_wdata       (core_wdata),
    .core_rdata       (core_rdata),
    .host_req         (host_req),
    .host_we          (host_we),
    .host_addr        (host_addr),
    .host_wdata       (host_wdata),
    .host_gnt         (host_gnt),
    .host_rvalid      (host_rvalid),
    .host_rdata       (host_rdata),
    .clear_start      (clear_start),
    .clear_words      (clear_words),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done),
    .core_hold        (core_hold),
    .err_core_in_clear(err_core_in_clear),
    .smem_ceb         (smem_ceb),
    .smem_web         (smem_web),
    .smem_addr        (smem_addr),
    .smem_wdata       (smem_wdata),
    .smem_rdata       (smem_rdata)
  );

  // SRAM model: preloaded with DEADBEEF_<index> while reset is held, 1-cycle read latency.
  always @(posedge clk) begin
    if (!resetB) begin
      for (int i = 0; i < 256; i++) mem[i] <= {32'hDEADBEEF, 32'(i)};
    end else if (!smem_ceb) begin
      if (!smem_web) mem[smem_addr[7:0]] <= smem_wdata;
      else           smem_rdata <= mem[smem_addr[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cceb, cweb;
    logic [15:0] caddr;
    logic [63:0] cwd;
    logic        hreq, hwe;
    logic [15:0] haddr;
    logic [63:0] hwd;
    logic        eceb, eweb, egnt;
    logic [15:0] eaddr;
    logic [63:0] ewd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0100, 64'h0, 1'b0, 1'b0, 16'h0000, 64'h0,
                1'b0, 1'b1, 1'b0, 16'h0100, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 16'h0101, 64'h1111, 1'b1, 1'b1, 16'h0200, 64'h9999,
                1'b0, 1'b0, 1'b0, 16'h0101, 64'h1111};
    vecs[2] = '{1'b1, 1'b1, 16'h0000, 64'h0, 1'b1, 1'b1, 16'h0201, 64'h2222,
                1'b0, 1'b0, 1'b1, 16'h0201, 64'h2222};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 64'h0, 1'b1, 1'b0, 16'h0202, 64'h3333,
                1'b0, 1'b1, 1'b1, 16'h0202, 64'h3333};
    vecs[4] = '{1'b1, 1'b1, 16'h0105, 64'h5555, 1'b0, 1'b0, 16'h0203, 64'h6666,
                1'b1, 1'b1, 1'b0, 16'h0000, 64'h0};
    vecs[5] = '{1'b0, 1'b1, 16'h0103, 64'h0, 1'b1, 1'b0, 16'h0204, 64'h0,
                1'b0, 1'b1, 1'b0, 16'h0103, 64'h0};

    // Reset with both requesters active.
    resetB = 1'b0; core_ceb = 1'b0; core_web = 1'b1; core_addr = 16'h1234; core_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0055; host_wdata = '0;
    clear_start = 1'b0; clear_words = '0;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("rst_smem_ceb", smem_ceb, 1);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_core_hold", core_hold, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_host_rvalid", host_rvalid, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_err", err_core_in_clear, 0);
    next_cyc();
    resetB = 1'b1;
    @(negedge clk);
    chk("post_rst_addr", smem_addr, 16'h1234);
    chk("post_rst_ceb", smem_ceb, 0);
    chk("post_rst_gnt", host_gnt, 0);
    next_cyc();
    core_ceb = 1'b1; host_req = 1'b0;
    next_cyc();

    // Mux vectors in IDLE.
    for (int i = 0; i < 6; i++) begin
      core_ceb = vecs[i].cceb; core_web = vecs[i].cweb;
      core_addr = vecs[i].caddr; core_wdata = vecs[i].cwd;
      host_req = vecs[i].hreq; host_we = vecs[i].hwe;
      host_addr = vecs[i].haddr; host_wdata = vecs[i].hwd;
      @(negedge clk);
      chk($sformatf("vec%0d_ceb", i), smem_ceb, vecs[i].eceb);
      chk($sformatf("vec%0d_web", i), smem_web, vecs[i].eweb);
      chk($sformatf("vec%0d_gnt", i), host_gnt, vecs[i].egnt);
      chk($sformatf("vec%0d_addr", i), smem_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d_wdata", i), smem_wdata, vecs[i].ewd);
      next_cyc();
    end
    core_ceb = 1'b1; host_req = 1'b0; host_we = 1'b0;
    repeat (3) next_cyc();

    // Host read with core idle: grant now, rvalid two edges later.
    host_req = 1'b1; host_addr = 16'h0010;
    @(negedge clk);
    chk("hrd_gnt", host_gnt, 1);
    chk("hrd_addr", smem_addr, 16'h0010);
    chk("hrd_web", smem_web, 1);
    next_cyc();
    host_req = 1'b0;
    @(negedge clk);
    chk("hrd_rvalid_early", host_rvalid, 0);
    next_cyc();
    @(negedge clk);
    chk("hrd_rvalid", host_rvalid, 1);
    chk("hrd_rdata", host_rdata, 64'hDEADBEEF_00000010);
    next_cyc();
    @(negedge clk);
    chk("hrd_rvalid_pulse", host_rvalid, 0);
    chk("hrd_rdata_hold", host_rdata, 64'hDEADBEEF_00000010);
    next_cyc();

    // Core and host collide: core first, host granted when core goes idle.
    core_ceb = 1'b0; core_web = 1'b1; core_addr = 16'h0020;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    chk("col_core_addr", smem_addr, 16'h0020);
    chk("col_gnt0", host_gnt, 0);
    next_cyc();
    core_ceb = 1'b1;
    @(negedge clk);
    chk("col_gnt1", host_gnt, 1);
    chk("col_host_addr", smem_addr, 16'h0030);
    chk("col_host_web", smem_web, 0);
    chk("col_core_rdata", core_rdata, 64'hDEADBEEF_00000020);
    next_cyc();
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("col_host_wr_mem", mem[8'h30], 64'hCAFE_F00D_1234_5678);
    chk("col_no_rvalid", host_rvalid, 0);
    next_cyc();

    // Four-word clear with a host request pending throughout.
    clear_words = 16'd4; clear_start = 1'b1;
    @(negedge clk);
    chk("clr4_busy_pre", clear_busy, 0);
    next_cyc();
    clear_start = 1'b0; host_req = 1'b1; host_addr = 16'h0050;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("clr4_hold%0d", k), core_hold, 1);
      chk($sformatf("clr4_ceb%0d", k), {smem_ceb, smem_web}, 2'b00);
      chk($sformatf("clr4_addr%0d", k), smem_addr, 16'(k));
      chk($sformatf("clr4_wdata%0d", k), smem_wdata, 0);
      chk($sformatf("clr4_gnt%0d", k), host_gnt, 0);
      chk($sformatf("clr4_done%0d", k), clear_done, 0);
      next_cyc();
    end
    @(negedge clk);
    chk("clr4_done", clear_done, 1);
    chk("clr4_hold_done", core_hold, 1);
    chk("clr4_ceb_done", smem_ceb, 1);
    chk("clr4_gnt_done", host_gnt, 0);
    next_cyc();
    @(negedge clk);
    chk("clr4_done_pulse", clear_done, 0);
    chk("clr4_busy_end", clear_busy, 0);
    chk("clr4_gnt_after", host_gnt, 1);
    next_cyc();
    host_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("clr4_mem%0d", k), mem[k], 0);
    chk("clr4_mem4", mem[4], 64'hDEADBEEF_00000004);
    repeat (3) next_cyc();

    // Zero-length clear.
    clear_words = 16'd0; clear_start = 1'b1;
    @(negedge clk);
    chk("clr0_busy_pre", clear_busy, 0);
    next_cyc();
    clear_start = 1'b0;
    @(negedge clk);
    chk("clr0_busy", clear_busy, 1);
    chk("clr0_no_write", smem_ceb, 1);
    chk("clr0_done_early", clear_done, 0);
    next_cyc();
    @(negedge clk);
    chk("clr0_done", clear_done, 1);
    chk("clr0_ceb_done", smem_ceb, 1);
    next_cyc();
    @(negedge clk);
    chk("clr0_busy_end", clear_busy, 0);
    chk("clr0_done_end", clear_done, 0);
    next_cyc();

    // Core write during a sweep is dropped and flagged; restart request ignored.
    chk("err_pre", err_core_in_clear, 0);
    clear_words = 16'd3; clear_start = 1'b1;
    next_cyc();
    clear_start = 1'b0;
    @(negedge clk);
    chk("err_clr_addr0", smem_addr, 16'h0000);
    next_cyc();
    core_ceb = 1'b0; core_web = 1'b0; core_addr = 16'h0040; core_wdata = 64'hAA;
    clear_start = 1'b1;
    @(negedge clk);
    chk("err_clr_addr1", smem_addr, 16'h0001);
    chk("err_clr_wdata1", smem_wdata, 0);
    chk("err_clr_web1", smem_web, 0);
    next_cyc();
    core_ceb = 1'b1; core_web = 1'b1; clear_start = 1'b0;
    @(negedge clk);
    chk("err_set", err_core_in_clear, 1);
    chk("err_clr_addr2", smem_addr, 16'h0002);
    next_cyc();
    @(negedge clk);
    chk("err_done", clear_done, 1);
    next_cyc();
    @(negedge clk);
    chk("err_sticky", err_core_in_clear, 1);
    chk("err_busy_end", clear_busy, 0);
    chk("err_mem_untouched", mem[8'h40], 64'hDEADBEEF_00000040);
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
